// File: rtl/arm_pkg.sv
// Shared types and widths for the ARM pipeline control blocks.
package arm_pkg;

  localparam int REG_W     = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking precedence over increment.
module sat_counter #(
  parameter int CNT_W = arm_pkg::CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush controller for the 5-stage pipeline: SRAM waits, taken branches
// and data hazards, with a memory-wait watchdog and saturating event counters.
module pipeline_hazard_ctrl
  import arm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_forward_en,
  input  logic [REG_W-1:0] i_id_src1,
  input  logic [REG_W-1:0] i_id_src2,
  input  logic             i_id_two_src,
  input  logic             i_id_uses_src1,
  input  logic             i_exe_wb_en,
  input  logic [REG_W-1:0] i_exe_dest,
  input  logic             i_exe_mem_r_en,
  input  logic             i_mem_wb_en,
  input  logic [REG_W-1:0] i_mem_dest,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_sram_ready,
  input  logic             i_cnt_clr,
  output logic             o_pc_freeze,
  output logic             o_if_freeze,
  output logic             o_if_flush,
  output logic             o_id_flush,
  output logic             o_back_freeze,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_hazard_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_wait_cnt
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  mem_state_t  r_state;
  logic [15:0] r_wd;
  logic        r_mem_err;

  logic w_mem_stall;
  logic w_src1_exe, w_src2_exe, w_src1_mem, w_src2_mem;
  logic w_hazard;
  logic w_hazard_sel, w_flush_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_wd      <= '0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd <= '0;
          if (i_mem_req && !i_sram_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (i_sram_ready) begin
            r_state <= IDLE;
            r_wd    <= '0;
          end else if (r_wd == WD_LAST) begin
            r_state   <= ERR;
            r_wd      <= '0;
            r_mem_err <= 1'b1;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_wd    <= '0;
        end
      endcase
    end
  end

  assign w_mem_stall = ((r_state == IDLE) && i_mem_req && !i_sram_ready) ||
                       ((r_state == WAIT) && !i_sram_ready);

  assign w_src1_exe = i_id_uses_src1 && i_exe_wb_en && (i_id_src1 == i_exe_dest);
  assign w_src2_exe = i_id_two_src   && i_exe_wb_en && (i_id_src2 == i_exe_dest);
  assign w_src1_mem = i_id_uses_src1 && i_mem_wb_en && (i_id_src1 == i_mem_dest);
  assign w_src2_mem = i_id_two_src   && i_mem_wb_en && (i_id_src2 == i_mem_dest);

  // With forwarding only a load still in EXE cannot be bypassed in time.
  assign w_hazard = i_forward_en ? (i_exe_mem_r_en && (w_src1_exe || w_src2_exe))
                                 : (w_src1_exe || w_src2_exe || w_src1_mem || w_src2_mem);

  assign w_flush_sel  = !w_mem_stall && i_branch_taken;
  assign w_hazard_sel = !w_mem_stall && !i_branch_taken && w_hazard;

  // Gated by reset so a held request cannot keep the pipeline frozen in reset.
  always_comb begin
    o_pc_freeze   = 1'b0;
    o_if_freeze   = 1'b0;
    o_if_flush    = 1'b0;
    o_id_flush    = 1'b0;
    o_back_freeze = 1'b0;
    if (i_rst_n) begin
      if (w_mem_stall) begin
        o_pc_freeze   = 1'b1;
        o_if_freeze   = 1'b1;
        o_back_freeze = 1'b1;
      end else if (i_branch_taken) begin
        o_if_flush = 1'b1;
        o_id_flush = 1'b1;
      end else if (w_hazard) begin
        o_pc_freeze = 1'b1;
        o_if_freeze = 1'b1;
        o_id_flush  = 1'b1;
      end
    end
  end

  assign o_mem_err = r_mem_err;

  sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_hazard_sel),
    .i_clr   (i_cnt_clr),
    .o_cnt   (o_hazard_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_flush_sel),
    .i_clr   (i_cnt_clr),
    .o_cnt   (o_flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_mem_stall),
    .i_clr   (i_cnt_clr),
    .o_cnt   (o_wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of hazard/branch vectors plus
// hand-written SRAM wait, watchdog, reset and counter saturation sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       forwardEn, idTwoSrc, idUsesSrc1, exeWbEn, exeMemREn, memWbEn;
  logic [3:0] idSrc1, idSrc2, exeDest, memDest;
  logic       branchTaken, memReq, sramReady, cntClr;

  logic        pcFreeze, ifFreeze, ifFlush, idFlush, backFreeze, memErr;
  logic [15:0] hazardCnt, flushCnt, waitCnt;

  logic        satPc, satIfFz, satIfFl, satIdFl, satBack, satErr;
  logic [1:0]  satHazard, satFlush, satWait;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    logic       fwd;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       uses1;
    logic       two;
    logic       exeWb;
    logic [3:0] exeDst;
    logic       exeLd;
    logic       memWb;
    logic [3:0] memDst;
    logic       br;
    logic [4:0] expOut;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_forward_en(forwardEn),
    .i_id_src1(idSrc1), .i_id_src2(idSrc2), .i_id_two_src(idTwoSrc),
    .i_id_uses_src1(idUsesSrc1), .i_exe_wb_en(exeWbEn), .i_exe_dest(exeDest),
    .i_exe_mem_r_en(exeMemREn), .i_mem_wb_en(memWbEn), .i_mem_dest(memDest),
    .i_branch_taken(branchTaken), .i_mem_req(memReq), .i_sram_ready(sramReady),
    .i_cnt_clr(cntClr), .o_pc_freeze(pcFreeze), .o_if_freeze(ifFreeze),
    .o_if_flush(ifFlush), .o_id_flush(idFlush), .o_back_freeze(backFreeze),
    .o_mem_err(memErr), .o_hazard_cnt(hazardCnt), .o_flush_cnt(flushCnt),
    .o_wait_cnt(waitCnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .TIMEOUT(8)) dutSat (
    .i_clk(clk), .i_rst_n(rstN), .i_forward_en(forwardEn),
    .i_id_src1(idSrc1), .i_id_src2(idSrc2), .i_id_two_src(idTwoSrc),
    .i_id_uses_src1(idUsesSrc1), .i_exe_wb_en(exeWbEn), .i_exe_dest(exeDest),
    .i_exe_mem_r_en(exeMemREn), .i_mem_wb_en(memWbEn), .i_mem_dest(memDest),
    .i_branch_taken(branchTaken), .i_mem_req(memReq), .i_sram_ready(sramReady),
    .i_cnt_clr(cntClr), .o_pc_freeze(satPc), .o_if_freeze(satIfFz),
    .o_if_flush(satIfFl), .o_id_flush(satIdFl), .o_back_freeze(satBack),
    .o_mem_err(satErr), .o_hazard_cnt(satHazard), .o_flush_cnt(satFlush),
    .o_wait_cnt(satWait)
  );

  function automatic vec_t mkVec(input string n, input logic fwd, input logic [3:0] s1,
                                 input logic [3:0] s2, input logic u1, input logic two,
                                 input logic ewb, input logic [3:0] ed, input logic eld,
                                 input logic mwb, input logic [3:0] md, input logic br,
                                 input logic [4:0] exp);
    vec_t v;
    v.name = n; v.fwd = fwd; v.src1 = s1; v.src2 = s2; v.uses1 = u1; v.two = two;
    v.exeWb = ewb; v.exeDst = ed; v.exeLd = eld; v.memWb = mwb; v.memDst = md;
    v.br = br; v.expOut = exp;
    return v;
  endfunction

  // Output bundle order: {pc_freeze, if_freeze, if_flush, id_flush, back_freeze}.
  function automatic logic [4:0] outs();
    return {pcFreeze, ifFreeze, ifFlush, idFlush, backFreeze};
  endfunction

  task automatic idleInputs();
    forwardEn = 1'b0; idSrc1 = 4'd0; idSrc2 = 4'd0; idTwoSrc = 1'b0; idUsesSrc1 = 1'b0;
    exeWbEn = 1'b0; exeDest = 4'd0; exeMemREn = 1'b0; memWbEn = 1'b0; memDest = 4'd0;
    branchTaken = 1'b0; memReq = 1'b0; sramReady = 1'b0; cntClr = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    forwardEn = v.fwd; idSrc1 = v.src1; idSrc2 = v.src2; idUsesSrc1 = v.uses1;
    idTwoSrc = v.two; exeWbEn = v.exeWb; exeDest = v.exeDst; exeMemREn = v.exeLd;
    memWbEn = v.memWb; memDest = v.memDst; branchTaken = v.br;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearCounters();
    @(negedge clk);
    idleInputs();
    cntClr = 1'b1;
    @(negedge clk);
    cntClr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    vecs[0]  = mkVec("loadUse",        1, 3, 0, 1, 0, 1, 3, 1, 0, 0, 0, 5'b11010);
    vecs[1]  = mkVec("noLoadFwd",      1, 3, 0, 1, 0, 1, 3, 0, 0, 0, 0, 5'b00000);
    vecs[2]  = mkVec("rawMemSrc2",     0, 0, 5, 0, 1, 0, 0, 0, 1, 5, 0, 5'b11010);
    vecs[3]  = mkVec("rawMemNoSrc2",   0, 0, 5, 0, 0, 0, 0, 0, 1, 5, 0, 5'b00000);
    vecs[4]  = mkVec("rawExeNoFwd",    0, 7, 0, 1, 0, 1, 7, 0, 0, 0, 0, 5'b11010);
    vecs[5]  = mkVec("exeMatchFwd",    1, 7, 0, 1, 0, 1, 7, 0, 0, 0, 0, 5'b00000);
    vecs[6]  = mkVec("branchOverHaz",  1, 3, 0, 1, 0, 1, 3, 1, 0, 0, 1, 5'b00110);
    vecs[7]  = mkVec("branchOnly",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00110);
    vecs[8]  = mkVec("noExeWb",        0, 3, 0, 1, 0, 0, 3, 0, 0, 0, 0, 5'b00000);
    vecs[9]  = mkVec("src1Unused",     1, 3, 0, 0, 0, 1, 3, 1, 0, 0, 0, 5'b00000);
    vecs[10] = mkVec("loadUseSrc2",    1, 0, 9, 0, 1, 1, 9, 1, 0, 0, 0, 5'b11010);
    vecs[11] = mkVec("memMatchFwd",    1, 5, 0, 1, 0, 0, 0, 0, 1, 5, 0, 5'b00000);

    $display("[TB] start");
    idleInputs();
    rstN = 1'b0;
    #1;
    checkOutput("resetOuts", 32'(outs()), 32'd0);
    checkOutput("resetErr", 32'(memErr), 32'd0);
    checkOutput("resetCnts", {hazardCnt, flushCnt | waitCnt}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i].name, 32'(outs()), 32'(vecs[i].expOut));
    end
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("tableHazardCnt", 32'(hazardCnt), 32'd4);
    checkOutput("tableFlushCnt", 32'(flushCnt), 32'd2);
    checkOutput("tableWaitCnt", 32'(waitCnt), 32'd0);
    checkOutput("tableSatHazard", 32'(satHazard), 32'd3);

    // SRAM wait: ready low for 4 cycles, then high.
    clearCounters();
    #1;
    checkOutput("clrHazardCnt", 32'(hazardCnt), 32'd0);
    @(negedge clk);
    memReq = 1'b1; sramReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checkOutput($sformatf("sramWait%0d", i), 32'(outs()), 32'b11001);
    end
    @(negedge clk);
    sramReady = 1'b1;
    #1;
    checkOutput("sramDone", 32'(outs()), 32'd0);
    @(negedge clk);
    memReq = 1'b0; sramReady = 1'b0;
    #1;
    checkOutput("sramWaitCnt", 32'(waitCnt), 32'd4);
    checkOutput("sramBackIdle", 32'(outs()), 32'd0);

    // Branch held through a 3-cycle SRAM wait.
    clearCounters();
    @(negedge clk);
    memReq = 1'b1; sramReady = 1'b0; branchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checkOutput($sformatf("brStall%0d", i), 32'(outs()), 32'b11001);
    end
    @(negedge clk);
    sramReady = 1'b1;
    #1;
    checkOutput("brAfterStall", 32'(outs()), 32'b00110);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("brFlushCnt", 32'(flushCnt), 32'd1);
    checkOutput("brWaitCnt", 32'(waitCnt), 32'd3);

    // Request with ready in the same cycle never leaves IDLE.
    @(negedge clk);
    memReq = 1'b1; sramReady = 1'b1;
    #1;
    checkOutput("reqReadyNoStall", 32'(outs()), 32'd0);
    @(negedge clk);
    memReq = 1'b0; sramReady = 1'b0;
    #1;
    checkOutput("reqReadyStayIdle", 32'(outs()), 32'd0);

    // Watchdog: one IDLE stall cycle plus eight WAIT cycles, then ERR.
    @(negedge clk);
    memReq = 1'b1; sramReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checkOutput($sformatf("wdStall%0d", i), 32'(outs()), 32'b11001);
      checkOutput($sformatf("wdNoErr%0d", i), 32'(memErr), 32'd0);
    end
    @(negedge clk);
    #1;
    checkOutput("wdReleased", 32'(outs()), 32'd0);
    checkOutput("wdErrSet", 32'(memErr), 32'd1);
    checkOutput("wdWaitCnt", 32'(waitCnt), 32'd12);
    @(negedge clk);
    memReq = 1'b0;
    #1;
    checkOutput("wdErrSticky1", 32'(memErr), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("wdErrSticky2", 32'(memErr), 32'd1);
    checkOutput("wdIdleOuts", 32'(outs()), 32'd0);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("wdErrReset", 32'(memErr), 32'd0);
    checkOutput("wdCntReset", 32'(waitCnt), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Reset asserted mid-WAIT with the request still held.
    @(negedge clk);
    memReq = 1'b1; sramReady = 1'b0;
    #1;
    checkOutput("midWaitStall0", 32'(outs()), 32'b11001);
    @(negedge clk);
    #1;
    checkOutput("midWaitStall1", 32'(outs()), 32'b11001);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midWaitResetOuts", 32'(outs()), 32'd0);
    @(negedge clk);
    memReq = 1'b0;
    rstN = 1'b1;
    #1;
    checkOutput("midWaitBackIdle", 32'(outs()), 32'd0);

    // Saturation on the 2-bit instance, then clear racing a hazard.
    clearCounters();
    @(negedge clk);
    applyStimulus(vecs[0]);
    repeat (4) @(negedge clk);
    @(negedge clk);
    cntClr = 1'b1;
    #1;
    checkOutput("satHazardCnt", 32'(satHazard), 32'd3);
    checkOutput("fullHazardCnt", 32'(hazardCnt), 32'd5);
    checkOutput("clrHazardOuts", 32'(outs()), 32'b11010);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("clrWinsSat", 32'(satHazard), 32'd0);
    checkOutput("clrWinsFull", 32'(hazardCnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central freeze/flush controller for the 5-stage ARM pipeline.
- Drives the freeze/flush inputs of the IF stage register, the PC, the ID/EXE register and the EXE/MEM/WB registers.
- Sources handled:
  - data hazards (load-use when forwarding is on, any RAW when it is off)
  - taken branches resolved in EXE
  - multi-cycle SRAM accesses issued from MEM
- Keeps saturating performance counters and a memory-wait watchdog.

Parameters:
- CNT_W, 16: width of each performance counter.
- TIMEOUT, 255: maximum WAIT cycles before the watchdog fires; must be ≥1 and < 2^16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- forward_en  in  1  forwarding unit enabled.
- id_src1  in  4  ID-stage source register 1.
- id_src2  in  4  ID-stage source register 2.
- id_two_src  in  1  id_src2 is a real operand.
- id_uses_src1  in  1  id_src1 is a real operand.
- exe_wb_en  in  1  EXE instruction writes a register.
- exe_dest  in  4  EXE destination register.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_wb_en  in  1  MEM instruction writes a register.
- mem_dest  in  4  MEM destination register.
- branch_taken  in  1  taken branch resolved in EXE.
- mem_req  in  1  MEM stage issues an SRAM read or write this cycle.
- sram_ready  in  1  SRAM controller completes the access.
- cnt_clr  in  1  synchronous clear of all counters.
- pc_freeze  out  1  hold the PC.
- if_freeze  out  1  hold the IF stage register.
- if_flush  out  1  zero the IF stage register.
- id_flush  out  1  load a bubble into the ID/EXE register.
- back_freeze  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- mem_err  out  1  sticky watchdog error.
- hazard_cnt  out  CNT_W  bubbles inserted.
- flush_cnt  out  CNT_W  branch flushes.
- wait_cnt  out  CNT_W  SRAM stall cycles.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, watchdog=0, mem_err=0, all counters=0. All outputs are combinational from FSM and inputs, so every freeze/flush output is 0 while in reset.
- Memory FSM, states IDLE / WAIT / ERR:
  - IDLE: mem_req & !sram_ready → WAIT. mem_req & sram_ready completes in the same cycle and stays in IDLE.
  - WAIT: sram_ready → IDLE. Otherwise the watchdog increments; when it reaches TIMEOUT-1 → ERR.
  - ERR: sets mem_err, releases the stall and returns to IDLE next cycle. mem_err stays 1 until reset.
  - Watchdog clears whenever the FSM is not in WAIT.
- mem_stall = (IDLE & mem_req & !sram_ready) | (WAIT & !sram_ready).
  - Combinational, so it is asserted the same cycle the request appears.
- Source match rule: a source matches a destination when its enable (id_uses_src1 / id_two_src) is 1, the corresponding wb_en is 1, and the 4-bit registers are equal.
- Data hazard:
  - forward_en=1: hazard = exe_mem_r_en & a source matches exe_dest.
  - forward_en=0: hazard = a source matches exe_dest, or a source matches mem_dest.
- Priority, highest first:
  1. mem_stall: pc_freeze = if_freeze = back_freeze = 1; if_flush = id_flush = 0. Branch and hazard are suppressed. EXE is frozen, so branch_taken persists and is serviced after the stall.
  2. branch_taken: if_flush = 1, id_flush = 1, no freeze. The hazard is ignored because the offending ID instruction is being flushed.
  3. hazard: pc_freeze = if_freeze = 1, id_flush = 1.
  4. Otherwise all 0.
- Counters (saturate at all-ones, never wrap):
  - hazard_cnt +1 on each cycle the priority-3 outputs are driven.
  - flush_cnt +1 on each priority-2 cycle.
  - wait_cnt +1 on each mem_stall cycle.
  - cnt_clr has precedence over increment; the counter reads 0 next cycle.
- Reset mid-WAIT: the FSM returns to IDLE immediately and freezes drop asynchronously.

Decomposition:
- Shared package `arm_pkg`:
  - register-index width (4)
  - FSM state enum `mem_state_t` {IDLE, WAIT, ERR}
  - default counter width constant
- One sub-module, `sat_counter` (CNT_W, inc, clr), instantiated three times.

Test Plan:
- Load-use:
  - forward_en=1, exe_mem_r_en=1, exe_dest=3, id_src1=3, id_uses_src1=1 → pc_freeze=if_freeze=id_flush=1 for 1 cycle, hazard_cnt=1.
  - Same stimulus with exe_mem_r_en=0 → all outputs 0.
- No-forwarding RAW: forward_en=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 → stall asserted. With id_two_src=0 → no stall.
- SRAM wait: mem_req=1, sram_ready low for 4 cycles then high → back_freeze=1 for exactly 4 cycles, wait_cnt=4, FSM back in IDLE.
- Branch during stall: branch_taken=1 held through a 3-cycle SRAM wait → no flush during the wait; if_flush=id_flush=1 on the first cycle after, flush_cnt=1.
- Watchdog: TIMEOUT=8, sram_ready held 0 → mem_err=1 after 8 WAIT cycles, stall released, mem_err sticky until rst=0.
- Saturation/clear: CNT_W=2, 5 hazard cycles → hazard_cnt=3. Assert cnt_clr together with a hazard → hazard_cnt=0.
